// File: rtl/ssp_pkg.sv
// -----------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the store buffer: default geometry, the drain FSM
// state encoding and the layout of one buffered store entry.
// No ports (package).
// -----------------------------------------------------------------------------
package ssp_pkg;

  localparam int SSP_DEPTH = 8;
  localparam int SSP_AW    = 10;
  localparam int SSP_DW    = 32;

  // Drain sequencing towards data memory.
  //   S_IDLE   : buffer empty, no write request
  //   S_WAIT   : entries present, last cycle saw no handshake
  //   S_RETIRE : last cycle retired an entry and more remain
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_RETIRE = 2'd2
  } drain_state_t;

  // One buffered store. Address/data fields use the package widths; a
  // buffer instance with narrower AW/DW zero-extends into these fields.
  typedef struct packed {
    logic              valid;
    logic [SSP_AW-1:0] addr;
    logic [SSP_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/ssp_store_buffer_if.sv
// -----------------------------------------------------------------------------
// ssp_store_buffer_if
// Bundles the store, load-forward and memory-drain signals of the store
// buffer.
//   master : the pipeline/memory side (drives requests and mem_ready)
//   slave  : the store buffer (drives ready, forward result, drain write,
//            occupancy status)
// -----------------------------------------------------------------------------
interface ssp_store_buffer_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 10,
  parameter int DW    = 32
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  // Store enqueue (bit 0 = older slot, bit 1 = younger slot)
  logic [1:0]    st_valid;
  logic [AW-1:0] st_addr0;
  logic [AW-1:0] st_addr1;
  logic [DW-1:0] st_data0;
  logic [DW-1:0] st_data1;
  logic          st_ready;

  // Load forwarding lookup
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;

  // Drain towards data memory
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;

  // Occupancy status
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output st_valid, st_addr0, st_addr1, st_data0, st_data1,
    output ld_valid, ld_addr, mem_ready,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata,
    input  count, full, empty
  );

  modport slave (
    input  st_valid, st_addr0, st_addr1, st_data0, st_data1,
    input  ld_valid, ld_addr, mem_ready,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata,
    output count, full, empty
  );

endinterface

// File: rtl/ssp_sb_fwd_match.sv
// -----------------------------------------------------------------------------
// ssp_sb_fwd_match
// Combinational store-to-load forwarding search. Scans the occupied entries
// from oldest (head) to youngest and reports the youngest address match.
// Ports:
//   entries  : store buffer contents (valid marks occupied entries)
//   head     : index of the oldest entry
//   ld_valid : lookup request
//   ld_addr  : load word address
//   hit      : a valid entry matches ld_addr
//   data     : data of the youngest match, zero when no hit
// -----------------------------------------------------------------------------
module ssp_sb_fwd_match
  import ssp_pkg::*;
#(
  parameter int DEPTH = SSP_DEPTH,
  parameter int AW    = SSP_AW,
  parameter int DW    = SSP_DW
) (
  input  sb_entry_t                    entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic                         ld_valid,
  input  logic [AW-1:0]                ld_addr,
  output logic                         hit,
  output logic [DW-1:0]                data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop; without it a path
    // that leaves hit/data unassigned would infer a latch.
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    // NOTE: blocking assignments in combinational logic, so a later
    // iteration overrides an earlier one within the same evaluation.
    // Walking oldest -> youngest therefore leaves the youngest match.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ld_valid && entries[idx].valid &&
          entries[idx].addr == SSP_AW'(ld_addr)) begin
        hit  = 1'b1;
        data = DW'(entries[idx].data);
      end
    end
  end

endmodule

// File: rtl/ssp_store_buffer.sv
// -----------------------------------------------------------------------------
// ssp_store_buffer
// Dual-issue store buffer: a circular FIFO of buffered stores that accepts up
// to two stores per cycle, forwards data to loads from the youngest matching
// entry, and drains one entry per cycle to data memory in program order.
// Ports:
//   clk1  : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : ssp_store_buffer_if.slave (store enqueue, load lookup, memory
//           drain, count/full/empty)
// -----------------------------------------------------------------------------
module ssp_store_buffer
  import ssp_pkg::*;
#(
  parameter int DEPTH = SSP_DEPTH,
  parameter int AW    = SSP_AW,
  parameter int DW    = SSP_DW
) (
  input  logic              clk1,
  input  logic              reset,
  ssp_store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     entries [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  drain_state_t  state_q;

  logic          st_ready;
  logic          accept;
  logic          retire;
  logic [1:0]    n_enq;
  logic [CW-1:0] count_next;

  // Room for a dual store is required even for a single store, so the
  // requester never has to split a pair.
  assign st_ready   = (CW'(DEPTH) - count_q) >= CW'(2);
  assign accept     = st_ready && (bus.st_valid != 2'b00);
  assign n_enq      = !accept ? 2'd0 : (bus.st_valid == 2'b11) ? 2'd2 : 2'd1;
  assign retire     = (state_q != S_IDLE) && bus.mem_ready;
  assign count_next = count_q + CW'(n_enq) - CW'(retire);

  always_ff @(posedge clk1) begin
    if (reset) begin
      // NOTE: only the valid bits are reset; address/data storage is left
      // alone since a cleared valid bit already hides stale contents.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // updates from the values seen before this edge.
      if (retire) begin
        entries[head_q].valid <= 1'b0;
        head_q                <= head_q + PW'(1);
      end

      // A retire and an enqueue never touch the same slot: enqueue needs at
      // least two free entries, so tail and tail+1 are never the head.
      if (accept) begin
        unique case (bus.st_valid)
          2'b01: begin
            entries[tail_q] <= '{valid: 1'b1, addr: SSP_AW'(bus.st_addr0),
                                 data: SSP_DW'(bus.st_data0)};
            tail_q          <= tail_q + PW'(1);
          end
          2'b10: begin
            entries[tail_q] <= '{valid: 1'b1, addr: SSP_AW'(bus.st_addr1),
                                 data: SSP_DW'(bus.st_data1)};
            tail_q          <= tail_q + PW'(1);
          end
          default: begin
            entries[tail_q]          <= '{valid: 1'b1, addr: SSP_AW'(bus.st_addr0),
                                          data: SSP_DW'(bus.st_data0)};
            entries[tail_q + PW'(1)] <= '{valid: 1'b1, addr: SSP_AW'(bus.st_addr1),
                                          data: SSP_DW'(bus.st_data1)};
            tail_q                   <= tail_q + PW'(2);
          end
        endcase
      end

      count_q <= count_next;

      // State tracks occupancy after this edge, so S_IDLE always coincides
      // with count==0 and can drive mem_we directly.
      if (count_next == '0) begin
        state_q <= S_IDLE;
      end else if (retire) begin
        state_q <= S_RETIRE;
      end else begin
        state_q <= S_WAIT;
      end
    end
  end

  ssp_sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entries  (entries),
    .head     (head_q),
    .ld_valid (bus.ld_valid),
    .ld_addr  (bus.ld_addr),
    .hit      (bus.ld_hit),
    .data     (bus.ld_data)
  );

  assign bus.st_ready  = st_ready;
  assign bus.mem_we    = (state_q != S_IDLE);
  assign bus.mem_addr  = AW'(entries[head_q].addr);
  assign bus.mem_wdata = DW'(entries[head_q].data);
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(DEPTH));
  assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_ssp_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_ssp_store_buffer
// Directed bench for ssp_store_buffer: reset state, dual-store drain order,
// forwarding priority, fill/full behaviour, pointer wrap and mid-drain reset.
// -----------------------------------------------------------------------------
module tb_ssp_store_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 10;
  localparam int DW    = 32;

  logic clk1 = 1'b0;
  logic reset;

  always #5 clk1 = ~clk1;

  ssp_store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  ssp_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory writes observed at each handshake, in order.
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            wr_cyc  [$];

  // One clock: record a handshake that will complete on the coming edge,
  // then advance to 1 time unit after that edge.
  task automatic cycle();
    #1;
    if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
    end
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.st_valid  = 2'b00;
    bus.st_addr0  = '0;
    bus.st_addr1  = '0;
    bus.st_data0  = '0;
    bus.st_data1  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.ld_valid = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    total++;
    if (bus.st_ready !== 1'b1) begin
      bad++; $display("FAIL reset_st_ready got=%b want=1", bus.st_ready);
    end
    total++;
    if (bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we);
    end
    total++;
    if (bus.ld_hit !== 1'b0 || bus.ld_data !== '0) begin
      bad++; $display("FAIL reset_ld got hit=%b data=%0d want hit=0 data=0", bus.ld_hit, bus.ld_data);
    end
    total++;
    if (bus.count !== 4'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", bus.count);
    end
    total++;
    if (bus.full !== 1'b0 || bus.empty !== 1'b1) begin
      bad++; $display("FAIL reset_full_empty got full=%b empty=%b want full=0 empty=1", bus.full, bus.empty);
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic test_dual_drain();
    logic [AW-1:0] ea [3];
    logic [DW-1:0] ed [3];
    ea = '{10'd15, 10'd16, 10'd17};
    ed = '{32'd100, 32'd200, 32'd300};
    do_reset();
    bus.mem_ready = 1'b1;
    bus.st_valid  = 2'b11;
    bus.st_addr0  = 10'd15; bus.st_data0 = 32'd100;
    bus.st_addr1  = 10'd16; bus.st_data1 = 32'd200;
    #1;
    total++;
    if (bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL drain_no_early_we got=%b want=0", bus.mem_we);
    end
    cycle();
    bus.st_valid = 2'b01;
    bus.st_addr0 = 10'd17; bus.st_data0 = 32'd300;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 10'd15;
    #1;
    total++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd15 || bus.mem_wdata !== 32'd100) begin
      bad++; $display("FAIL drain_head got we=%b addr=%0d data=%0d want we=1 addr=15 data=100",
                      bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    // The head retires on the coming edge but is still forwardable now.
    total++;
    if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd100) begin
      bad++; $display("FAIL fwd_retiring got hit=%b data=%0d want hit=1 data=100", bus.ld_hit, bus.ld_data);
    end
    cycle();
    bus.st_valid = 2'b00;
    bus.ld_valid = 1'b0;
    repeat (4) cycle();
    total++;
    if (wr_addr.size() != 3) begin
      bad++; $display("FAIL drain_write_count got=%0d want=3", wr_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr.size()) begin
        total++;
        if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_cyc[i] != wr_cyc[0] + i) begin
          bad++; $display("FAIL drain_write%0d got addr=%0d data=%0d cyc+%0d want addr=%0d data=%0d cyc+%0d",
                          i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], ea[i], ed[i], i);
        end
      end
    end
    total++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL drain_empty_after got empty=%b count=%0d we=%b want empty=1 count=0 we=0",
                      bus.empty, bus.count, bus.mem_we);
    end
  endtask

  task automatic test_forward();
    do_reset();
    bus.st_valid = 2'b01;
    bus.st_addr0 = 10'd50; bus.st_data0 = 32'd100;
    cycle();
    bus.st_data0 = 32'd200;
    cycle();
    bus.st_valid = 2'b00;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 10'd50;
    #1;
    total++;
    if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd200) begin
      bad++; $display("FAIL fwd_youngest got hit=%b data=%0d want hit=1 data=200", bus.ld_hit, bus.ld_data);
    end
    bus.ld_addr = 10'd40;
    #1;
    total++;
    if (bus.ld_hit !== 1'b0 || bus.ld_data !== 32'd0) begin
      bad++; $display("FAIL fwd_miss got hit=%b data=%0d want hit=0 data=0", bus.ld_hit, bus.ld_data);
    end
    bus.ld_valid = 1'b0;
    bus.ld_addr  = 10'd50;
    #1;
    total++;
    if (bus.ld_hit !== 1'b0 || bus.ld_data !== 32'd0) begin
      bad++; $display("FAIL fwd_no_valid got hit=%b data=%0d want hit=0 data=0", bus.ld_hit, bus.ld_data);
    end
    // A store being enqueued this cycle is not visible yet.
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 10'd60;
    bus.st_valid = 2'b01;
    bus.st_addr0 = 10'd60; bus.st_data0 = 32'd7;
    #1;
    total++;
    if (bus.ld_hit !== 1'b0) begin
      bad++; $display("FAIL fwd_same_cycle got hit=%b want hit=0", bus.ld_hit);
    end
    cycle();
    bus.st_valid = 2'b00;
    #1;
    total++;
    if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd7) begin
      bad++; $display("FAIL fwd_next_cycle got hit=%b data=%0d want hit=1 data=7", bus.ld_hit, bus.ld_data);
    end
    // Slot 1 of a dual store is younger than slot 0.
    bus.st_valid = 2'b11;
    bus.st_addr0 = 10'd70; bus.st_data0 = 32'd1;
    bus.st_addr1 = 10'd70; bus.st_data1 = 32'd2;
    cycle();
    bus.st_valid = 2'b00;
    bus.ld_addr  = 10'd70;
    #1;
    total++;
    if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd2) begin
      bad++; $display("FAIL fwd_dual_slot got hit=%b data=%0d want hit=1 data=2", bus.ld_hit, bus.ld_data);
    end
    total++;
    if (bus.count !== 4'd5) begin
      bad++; $display("FAIL fwd_count got=%0d want=5", bus.count);
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.st_ready !== 1'b1) begin
        bad++; $display("FAIL fill_ready_at%0d got=%b want=1", i, bus.st_ready);
      end
      bus.st_valid = 2'b01;
      bus.st_addr0 = AW'(100 + i); bus.st_data0 = DW'(3 * i + 1);
      cycle();
    end
    bus.st_valid = 2'b00;
    #1;
    total++;
    if (bus.count !== 4'd6 || bus.st_ready !== 1'b1 || bus.full !== 1'b0) begin
      bad++; $display("FAIL fill_six got count=%0d ready=%b full=%b want count=6 ready=1 full=0",
                      bus.count, bus.st_ready, bus.full);
    end
    bus.st_valid = 2'b11;
    bus.st_addr0 = 10'd106; bus.st_data0 = 32'd19;
    bus.st_addr1 = 10'd107; bus.st_data1 = 32'd22;
    cycle();
    bus.st_valid = 2'b00;
    #1;
    total++;
    if (bus.count !== 4'd8 || bus.st_ready !== 1'b0 || bus.full !== 1'b1) begin
      bad++; $display("FAIL fill_full got count=%0d ready=%b full=%b want count=8 ready=0 full=1",
                      bus.count, bus.st_ready, bus.full);
    end
    // Request while not ready is dropped.
    bus.st_valid = 2'b01;
    bus.st_addr0 = 10'd900; bus.st_data0 = 32'd5;
    cycle();
    total++;
    if (bus.count !== 4'd8) begin
      bad++; $display("FAIL fill_drop_count got=%0d want=8", bus.count);
    end
    // Full buffer: dual store refused, one entry still retires.
    bus.st_valid  = 2'b11;
    bus.st_addr0  = 10'd901; bus.st_addr1 = 10'd902;
    bus.mem_ready = 1'b1;
    cycle();
    bus.st_valid  = 2'b00;
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.count !== 4'd7 || bus.full !== 1'b0 || bus.st_ready !== 1'b0) begin
      bad++; $display("FAIL full_retire got count=%0d full=%b ready=%b want count=7 full=0 ready=0",
                      bus.count, bus.full, bus.st_ready);
    end
    bus.ld_valid = 1'b1;
    for (int a = 900; a <= 902; a++) begin
      bus.ld_addr = AW'(a);
      #1;
      total++;
      if (bus.ld_hit !== 1'b0) begin
        bad++; $display("FAIL fill_refused_addr%0d got hit=%b want hit=0", a, bus.ld_hit);
      end
    end
    bus.ld_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (10) cycle();
    bus.mem_ready = 1'b0;
    total++;
    if (wr_addr.size() != 8) begin
      bad++; $display("FAIL fill_drain_count got=%0d want=8", wr_addr.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < wr_addr.size()) begin
        total++;
        if (wr_addr[i] !== AW'(100 + i) || wr_data[i] !== DW'(3 * i + 1)) begin
          bad++; $display("FAIL fill_drain%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                          i, wr_addr[i], wr_data[i], 100 + i, 3 * i + 1);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int sent   = 0;
    int budget = 0;
    do_reset();
    while ((sent < 20 || bus.empty !== 1'b1) && budget < 400) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      if (sent < 20 && bus.st_ready === 1'b1) begin
        bus.st_valid = 2'b01;
        bus.st_addr0 = AW'(200 + sent);
        bus.st_data0 = DW'(1000 + 7 * sent);
        sent++;
      end else begin
        bus.st_valid = 2'b00;
      end
      cycle();
      budget++;
    end
    bus.st_valid  = 2'b00;
    bus.mem_ready = 1'b0;
    total++;
    if (budget >= 400) begin
      bad++; $display("FAIL wrap_timeout sent=%0d empty=%b want all drained within 400 cycles", sent, bus.empty);
    end
    total++;
    if (wr_addr.size() != 20) begin
      bad++; $display("FAIL wrap_write_count got=%0d want=20", wr_addr.size());
    end
    for (int i = 0; i < 20; i++) begin
      if (i < wr_addr.size()) begin
        total++;
        if (wr_addr[i] !== AW'(200 + i) || wr_data[i] !== DW'(1000 + 7 * i)) begin
          bad++; $display("FAIL wrap_write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                          i, wr_addr[i], wr_data[i], 200 + i, 1000 + 7 * i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.st_valid = 2'b01;
      bus.st_addr0 = AW'(300 + i); bus.st_data0 = DW'(i + 1);
      cycle();
    end
    bus.st_valid = 2'b00;
    #1;
    total++;
    if (bus.count !== 4'd5) begin
      bad++; $display("FAIL rstmid_pre_count got=%0d want=5", bus.count);
    end
    // Reset wins over a simultaneous dual enqueue and retire.
    reset         = 1'b1;
    bus.st_valid  = 2'b11;
    bus.st_addr0  = 10'd310; bus.st_addr1 = 10'd311;
    bus.mem_ready = 1'b1;
    cycle();
    reset        = 1'b0;
    bus.st_valid = 2'b00;
    #1;
    total++;
    if (bus.count !== 4'd0 || bus.mem_we !== 1'b0 || bus.empty !== 1'b1 || bus.st_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_state got count=%0d we=%b empty=%b ready=%b want count=0 we=0 empty=1 ready=1",
                      bus.count, bus.mem_we, bus.empty, bus.st_ready);
    end
    bus.ld_valid = 1'b1;
    for (int a = 300; a <= 311; a++) begin
      if (a <= 304 || a >= 310) begin
        bus.ld_addr = AW'(a);
        #1;
        total++;
        if (bus.ld_hit !== 1'b0 || bus.ld_data !== '0) begin
          bad++; $display("FAIL rstmid_ld%0d got hit=%b data=%0d want hit=0 data=0", a, bus.ld_hit, bus.ld_data);
        end
      end
    end
    bus.ld_valid = 1'b0;
    cycle();
    total++;
    if (bus.count !== 4'd0 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got count=%0d we=%b want count=0 we=0", bus.count, bus.mem_we);
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_dual_drain();
    test_forward();
    test_fill();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish by time 200000");
    $fatal(1, "watchdog");
  end

endmodule
